store_buffer: RTL and testbench
===============================

# store_buffer

In-order store buffer between rename, the store functional unit, the ROB and data memory. It allocates one entry per store at rename and captures the address and data when the store executes. Entries are marked committed in program order on ROB retire and drained to memory one per handshake. Toward the issue table it returns a per-issue-entry clear vector, so wait-for-store instructions become eligible once their referenced store has executed or drained.

## Interface
- SB_ENTRY, 8, number of entries; power of two, at least 2; SBW = $clog2(SB_ENTRY)
- ISSUE_ENTRY, 16, issue-table depth; width of the clear vector
- WORD_SIZE_P, 16, address and data width
- clk_i  in  1  clock; all state updates on the rising edge
- reset_n_i  in  1  reset; asynchronous assert, active-low
- alloc_v_i  in  1  rename requests a store entry
- alloc_ready_o  out  1  an entry is free (count != SB_ENTRY)
- alloc_id_o  out  SBW  index of the entry that will be allocated (the tail)
- exec_v_i  in  1  store FU delivers a resolved address and data
- exec_id_i  in  SBW  entry being executed
- exec_addr_i  in  WORD_SIZE_P  store address
- exec_data_i  in  WORD_SIZE_P  store data
- commit_v_i  in  1  ROB retires the oldest uncommitted store
- flush_i  in  1  mispredict; squash every uncommitted entry
- mem_v_o  out  1  the head entry is committed and presented to memory
- mem_addr_o  out  WORD_SIZE_P  head address
- mem_data_o  out  WORD_SIZE_P  head data
- mem_ready_i  in  1  memory accepts the head this cycle
- issue_sb_num_vector_i  in  ISSUE_ENTRY×SBW  SB entry each issue slot waits on
- st_clear_vector_o  out  ISSUE_ENTRY  bit k set when issue slot k's store is resolved
- err_o  out  1  sticky protocol error

## Operation
- Per-entry state: valid, exec, cmt, addr, data.
- Three pointers, each SBW+1 bits (the extra bit is a wrap bit):
  - head: oldest entry, the drain point
  - cptr: next entry to commit
  - tail: next entry to allocate
- count = tail − head, modulo 2^(SBW+1).
- Allocate:
  - Fires when alloc_v_i & alloc_ready_o & ~flush_i.
  - entry[tail] gets valid=1, exec=0, cmt=0; tail increments.
- Execute:
  - Fires when exec_v_i & ~flush_i & entry[exec_id_i].valid & ~cmt.
  - Writes addr and data and sets exec=1.
  - An exec to an invalid or already-committed entry sets err_o and changes nothing.
- Commit:
  - Fires when commit_v_i & cptr != tail & entry[cptr].exec (registered value).
  - Sets cmt=1; cptr increments.
  - Commit with cptr == tail or exec=0 sets err_o and is ignored.
  - An exec to the same entry in the same cycle does not satisfy commit.
- Drain:
  - mem_v_o = entry[head].valid & entry[head].cmt.
  - On mem_v_o & mem_ready_i: entry[head].valid=0, all bits cleared; head increments.
- Flush:
  - tail ← cptr.
  - valid, exec and cmt cleared on every entry from cptr up to (not including) the old tail.
  - Committed entries keep draining.
  - Alloc, exec and commit in a flush cycle are ignored. Drain still occurs.
- Clear vector: st_clear_vector_o[k] = ~entry[n].valid | entry[n].exec, where n = issue_sb_num_vector_i[k]. It is purely combinational.
- err_o: set by any protocol error listed above; cleared only by reset.

## Timing
- Reset (asynchronous, reset_n_i=0): all pointers 0, all entry bits 0, err_o=0.
  - Outputs during and after reset: alloc_ready_o=1, alloc_id_o=0, mem_v_o=0, mem_addr_o=0, mem_data_o=0, st_clear_vector_o all 1.
  - Reset mid-drain drops mem_v_o immediately and loses every entry.
- alloc_ready_o, alloc_id_o, mem_* and st_clear_vector_o are combinational from registered state only. There is no input-to-output path except issue_sb_num_vector_i → st_clear_vector_o.
- Latencies:
  - Allocated entry is visible (clear bit drops to 0) the cycle after alloc.
  - Exec → clear bit = 1 the next cycle.
  - Exec → earliest commit the next cycle.
  - Commit → mem_v_o the next cycle if the entry is at head.
- Throughput: one alloc, one exec, one commit and one drain may all occur in the same cycle, each on a different entry.
- Full (count = SB_ENTRY): alloc_ready_o=0. A drain in that cycle does not raise alloc_ready_o until the next cycle; there is no same-cycle bypass.
- Empty: mem_v_o=0, and every clear bit whose entry is invalid reads 1.
- Wrap-around: pointer index bits wrap to 0 and the wrap bit toggles; full versus empty is distinguished by the wrap bit.
- A held mem_v_o with mem_ready_i=0 keeps mem_addr_o and mem_data_o stable.

## Test plan
- Reset then idle: alloc_ready_o=1, alloc_id_o=0, mem_v_o=0, st_clear_vector_o=16'hFFFF, err_o=0.
- Single store:
  - Stimulus: alloc (id 0); exec id 0, addr 16'h0040, data 16'hBEEF; commit; mem_ready_i=1.
  - Required: mem_v_o appears one cycle after commit with 16'h0040 / 16'hBEEF. Issue slot 3 pointing at entry 0 reads clear 0 after alloc and 1 after exec. Afterwards count = 0.
- Fill and wrap:
  - Stimulus: 8 allocs, with mem_ready_i=0 throughout so nothing drains yet.
  - Required: alloc_ready_o=0 and a 9th alloc is ignored. Then exec, commit and drain all 8. Then alloc 3 more: ids 0, 1, 2, and the wrap bit has toggled.
- Flush:
  - Stimulus: alloc 5, exec all, commit 2, assert flush_i.
  - Required: tail = cptr = 2. Entries 2–4 invalid, and their clear bits read 1. Entries 0 and 1 still drain in order. The next alloc_id_o = 2.
- Protocol errors: commit with an unexecuted head, and exec to an invalid entry → err_o=1 and stays 1; entry state unchanged.
- Async reset mid-drain:
  - Stimulus: reset_n_i falls while mem_v_o=1 and mem_ready_i=0.
  - Required: mem_v_o goes to 0 without waiting for a clock edge; all pointers are 0 on release.

Source files
------------

// File: rtl/store_buffer.sv
// In-order store buffer: allocates at rename, captures address/data on execute,
// commits in program order on retire and drains committed entries to memory.
module store_buffer #(
  parameter  int SB_ENTRY    = 8,
  parameter  int ISSUE_ENTRY = 16,
  parameter  int WORD_SIZE_P = 16,
  localparam int SBW         = $clog2(SB_ENTRY)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       alloc_v_i,
  output logic                       alloc_ready_o,
  output logic [SBW-1:0]             alloc_id_o,
  input  logic                       exec_v_i,
  input  logic [SBW-1:0]             exec_id_i,
  input  logic [WORD_SIZE_P-1:0]     exec_addr_i,
  input  logic [WORD_SIZE_P-1:0]     exec_data_i,
  input  logic                       commit_v_i,
  input  logic                       flush_i,
  output logic                       mem_v_o,
  output logic [WORD_SIZE_P-1:0]     mem_addr_o,
  output logic [WORD_SIZE_P-1:0]     mem_data_o,
  input  logic                       mem_ready_i,
  input  logic [ISSUE_ENTRY*SBW-1:0] issue_sb_num_vector_i,
  output logic [ISSUE_ENTRY-1:0]     st_clear_vector_o,
  output logic                       err_o
);

  logic [SBW:0]             head_r, cptr_r, tail_r;
  logic [SB_ENTRY-1:0]      valid_r, exec_r, cmt_r;
  logic [WORD_SIZE_P-1:0]   addr_r [SB_ENTRY];
  logic [WORD_SIZE_P-1:0]   data_r [SB_ENTRY];
  logic                     err_r;

  logic [SBW-1:0]           head_idx_s, cptr_idx_s, tail_idx_s;
  logic [SBW:0]             count_s, ucnt_s;
  logic                     alloc_fire_s, exec_fire_s, commit_fire_s, drain_s;
  logic                     exec_err_s, commit_err_s;
  logic [SB_ENTRY-1:0]      flush_mask_s;

  assign head_idx_s = head_r[SBW-1:0];
  assign cptr_idx_s = cptr_r[SBW-1:0];
  assign tail_idx_s = tail_r[SBW-1:0];
  assign count_s    = tail_r - head_r;
  assign ucnt_s     = tail_r - cptr_r;

  assign alloc_ready_o = (count_s != (SBW+1)'(SB_ENTRY));
  assign alloc_id_o    = tail_idx_s;
  assign mem_v_o       = valid_r[head_idx_s] & cmt_r[head_idx_s];
  assign mem_addr_o    = addr_r[head_idx_s];
  assign mem_data_o    = data_r[head_idx_s];
  assign err_o         = err_r;

  // Event qualification and protocol error detection from registered state
  always_comb begin
    alloc_fire_s  = alloc_v_i & alloc_ready_o & ~flush_i;
    drain_s       = mem_v_o & mem_ready_i;
    exec_fire_s   = 1'b0;
    exec_err_s    = 1'b0;
    commit_fire_s = 1'b0;
    commit_err_s  = 1'b0;
    if (exec_v_i && !flush_i) begin
      if (valid_r[exec_id_i] && !cmt_r[exec_id_i]) begin
        exec_fire_s = 1'b1;
      end else begin
        exec_err_s = 1'b1;
      end
    end else begin
      exec_fire_s = 1'b0;
    end
    if (commit_v_i && !flush_i) begin
      if ((cptr_r != tail_r) && exec_r[cptr_idx_s]) begin
        commit_fire_s = 1'b1;
      end else begin
        commit_err_s = 1'b1;
      end
    end else begin
      commit_fire_s = 1'b0;
    end
  end

  // Entries in the uncommitted window [cptr, tail) are the ones a flush squashes
  always_comb begin
    flush_mask_s = '0;
    for (int i = 0; i < SB_ENTRY; i++) begin
      flush_mask_s[i] = ({1'b0, SBW'(SBW'(i) - cptr_idx_s)} < ucnt_s);
    end
  end

  // Clear vector lookup: an issue slot is released when its store is gone or executed
  always_comb begin
    st_clear_vector_o = '0;
    for (int k = 0; k < ISSUE_ENTRY; k++) begin
      st_clear_vector_o[k] = ~valid_r[issue_sb_num_vector_i[k*SBW +: SBW]]
                           | exec_r[issue_sb_num_vector_i[k*SBW +: SBW]];
    end
  end

  // Head, commit and tail pointers plus the sticky error flag
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_r <= '0;
      cptr_r <= '0;
      tail_r <= '0;
      err_r  <= 1'b0;
    end else begin
      err_r <= err_r | exec_err_s | commit_err_s;
      if (drain_s) begin
        head_r <= head_r + (SBW+1)'(1);
      end
      if (commit_fire_s) begin
        cptr_r <= cptr_r + (SBW+1)'(1);
      end
      if (flush_i) begin
        tail_r <= cptr_r;
      end else if (alloc_fire_s) begin
        tail_r <= tail_r + (SBW+1)'(1);
      end
    end
  end

  // Per-entry state; drain and flush clear, otherwise alloc/exec/commit set bits
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_r <= '0;
      exec_r  <= '0;
      cmt_r   <= '0;
      for (int i = 0; i < SB_ENTRY; i++) begin
        addr_r[i] <= '0;
        data_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SB_ENTRY; i++) begin
        if (drain_s && (head_idx_s == SBW'(i))) begin
          valid_r[i] <= 1'b0;
          exec_r[i]  <= 1'b0;
          cmt_r[i]   <= 1'b0;
          addr_r[i]  <= '0;
          data_r[i]  <= '0;
        end else if (flush_i && flush_mask_s[i]) begin
          valid_r[i] <= 1'b0;
          exec_r[i]  <= 1'b0;
          cmt_r[i]   <= 1'b0;
        end else begin
          if (alloc_fire_s && (tail_idx_s == SBW'(i))) begin
            valid_r[i] <= 1'b1;
            exec_r[i]  <= 1'b0;
            cmt_r[i]   <= 1'b0;
          end
          if (exec_fire_s && (exec_id_i == SBW'(i))) begin
            exec_r[i] <= 1'b1;
            addr_r[i] <= exec_addr_i;
            data_r[i] <= exec_data_i;
          end
          if (commit_fire_s && (cptr_idx_s == SBW'(i))) begin
            cmt_r[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        alloc_v_i;
  logic        alloc_ready_o;
  logic [2:0]  alloc_id_o;
  logic        exec_v_i;
  logic [2:0]  exec_id_i;
  logic [15:0] exec_addr_i;
  logic [15:0] exec_data_i;
  logic        commit_v_i;
  logic        flush_i;
  logic        mem_v_o;
  logic [15:0] mem_addr_o;
  logic [15:0] mem_data_o;
  logic        mem_ready_i;
  logic [47:0] issue_sb_num_vector_i;
  logic [15:0] st_clear_vector_o;
  logic        err_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  store_buffer dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .alloc_v_i(alloc_v_i), .alloc_ready_o(alloc_ready_o), .alloc_id_o(alloc_id_o),
    .exec_v_i(exec_v_i), .exec_id_i(exec_id_i), .exec_addr_i(exec_addr_i),
    .exec_data_i(exec_data_i), .commit_v_i(commit_v_i), .flush_i(flush_i),
    .mem_v_o(mem_v_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ready_i(mem_ready_i), .issue_sb_num_vector_i(issue_sb_num_vector_i),
    .st_clear_vector_o(st_clear_vector_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // issue slot k waits on entry (k+5)&7, so entry e is seen at slot (e+3)&7
  function automatic int slot_of(input int e);
    return (e + 3) & 7;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_v_i = 1'b0; exec_v_i = 1'b0; exec_id_i = 3'd0;
    exec_addr_i = 16'h0000; exec_data_i = 16'h0000;
    commit_v_i = 1'b0; flush_i = 1'b0; mem_ready_i = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n_i = 1'b0;
    tick();
    tick();
    reset_n_i = 1'b1;
    #1;
  endtask

  task automatic do_alloc();
    alloc_v_i = 1'b1; tick(); alloc_v_i = 1'b0;
  endtask

  task automatic do_exec(input logic [2:0] id, input logic [15:0] a, input logic [15:0] d);
    exec_v_i = 1'b1; exec_id_i = id; exec_addr_i = a; exec_data_i = d;
    tick();
    exec_v_i = 1'b0;
  endtask

  task automatic do_commit();
    commit_v_i = 1'b1; tick(); commit_v_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++; if (alloc_ready_o !== 1'b1) $display("FAIL reset_alloc_ready got %b exp 1", alloc_ready_o); else pass_cnt++;
    total_cnt++; if (alloc_id_o !== 3'd0) $display("FAIL reset_alloc_id got %0d exp 0", alloc_id_o); else pass_cnt++;
    total_cnt++; if (mem_v_o !== 1'b0) $display("FAIL reset_mem_v got %b exp 0", mem_v_o); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== 16'h0000 || mem_data_o !== 16'h0000)
      $display("FAIL reset_mem_bus got %h/%h exp 0000/0000", mem_addr_o, mem_data_o); else pass_cnt++;
    total_cnt++; if (st_clear_vector_o !== 16'hFFFF) $display("FAIL reset_clear got %h exp FFFF", st_clear_vector_o); else pass_cnt++;
    total_cnt++; if (err_o !== 1'b0) $display("FAIL reset_err got %b exp 0", err_o); else pass_cnt++;
  endtask

  task automatic test_single_store();
    apply_reset();
    do_alloc();
    total_cnt++; if (st_clear_vector_o[3] !== 1'b0) $display("FAIL single_clear_after_alloc got %b exp 0", st_clear_vector_o[3]); else pass_cnt++;
    do_exec(3'd0, 16'h0040, 16'hBEEF);
    total_cnt++; if (st_clear_vector_o[3] !== 1'b1) $display("FAIL single_clear_after_exec got %b exp 1", st_clear_vector_o[3]); else pass_cnt++;
    total_cnt++; if (mem_v_o !== 1'b0) $display("FAIL single_mem_v_before_commit got %b exp 0", mem_v_o); else pass_cnt++;
    do_commit();
    total_cnt++; if (mem_v_o !== 1'b1) $display("FAIL single_mem_v got %b exp 1", mem_v_o); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== 16'h0040 || mem_data_o !== 16'hBEEF)
      $display("FAIL single_mem_bus got %h/%h exp 0040/BEEF", mem_addr_o, mem_data_o); else pass_cnt++;
    tick();
    total_cnt++; if (mem_addr_o !== 16'h0040) $display("FAIL single_hold_addr got %h exp 0040", mem_addr_o); else pass_cnt++;
    mem_ready_i = 1'b1; tick(); mem_ready_i = 1'b0;
    total_cnt++; if (mem_v_o !== 1'b0) $display("FAIL single_after_drain_mem_v got %b exp 0", mem_v_o); else pass_cnt++;
    total_cnt++; if (alloc_id_o !== 3'd1 || alloc_ready_o !== 1'b1)
      $display("FAIL single_after_drain_ptr got id %0d rdy %b exp id 1 rdy 1", alloc_id_o, alloc_ready_o); else pass_cnt++;
    total_cnt++; if (st_clear_vector_o !== 16'hFFFF) $display("FAIL single_empty_clear got %h exp FFFF", st_clear_vector_o); else pass_cnt++;
  endtask

  task automatic test_fill_wrap();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      total_cnt++; if (alloc_id_o !== 3'(i)) $display("FAIL fill_alloc_id got %0d exp %0d", alloc_id_o, i); else pass_cnt++;
      do_alloc();
    end
    total_cnt++; if (alloc_ready_o !== 1'b0) $display("FAIL fill_full_ready got %b exp 0", alloc_ready_o); else pass_cnt++;
    do_alloc();
    total_cnt++; if (alloc_ready_o !== 1'b0 || alloc_id_o !== 3'd0)
      $display("FAIL fill_ninth_ignored got rdy %b id %0d exp rdy 0 id 0", alloc_ready_o, alloc_id_o); else pass_cnt++;
    for (int i = 0; i < 8; i++) do_exec(3'(i), 16'h0100 + 16'(i), 16'hA000 + 16'(i));
    for (int i = 0; i < 8; i++) do_commit();
    total_cnt++; if (err_o !== 1'b0) $display("FAIL fill_err got %b exp 0", err_o); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total_cnt++; if (mem_v_o !== 1'b1 || mem_addr_o !== 16'h0100 + 16'(i) || mem_data_o !== 16'hA000 + 16'(i))
        $display("FAIL fill_drain_%0d got v %b %h/%h exp v 1 %h/%h", i, mem_v_o, mem_addr_o, mem_data_o,
                 16'h0100 + 16'(i), 16'hA000 + 16'(i)); else pass_cnt++;
      if (i == 0) begin
        total_cnt++; if (alloc_ready_o !== 1'b0) $display("FAIL fill_no_bypass got %b exp 0", alloc_ready_o); else pass_cnt++;
      end
      mem_ready_i = 1'b1; tick(); mem_ready_i = 1'b0;
      if (i == 0) begin
        total_cnt++; if (alloc_ready_o !== 1'b1) $display("FAIL fill_ready_after_drain got %b exp 1", alloc_ready_o); else pass_cnt++;
      end
    end
    total_cnt++; if (mem_v_o !== 1'b0) $display("FAIL fill_empty_mem_v got %b exp 0", mem_v_o); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (alloc_id_o !== 3'(i)) $display("FAIL wrap_alloc_id got %0d exp %0d", alloc_id_o, i); else pass_cnt++;
      do_alloc();
    end
    total_cnt++; if (st_clear_vector_o[slot_of(2)] !== 1'b0 || st_clear_vector_o[slot_of(3)] !== 1'b1)
      $display("FAIL wrap_clear got e2 %b e3 %b exp e2 0 e3 1", st_clear_vector_o[slot_of(2)], st_clear_vector_o[slot_of(3)]); else pass_cnt++;
    for (int i = 0; i < 4; i++) do_alloc();
    total_cnt++; if (alloc_ready_o !== 1'b1) $display("FAIL wrap_seven_ready got %b exp 1", alloc_ready_o); else pass_cnt++;
    do_alloc();
    total_cnt++; if (alloc_ready_o !== 1'b0) $display("FAIL wrap_full_again got %b exp 0", alloc_ready_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_alloc();
    alloc_v_i = 1'b1; exec_v_i = 1'b1; exec_id_i = 3'd0; exec_addr_i = 16'h0300; exec_data_i = 16'h3000;
    tick();
    exec_id_i = 3'd1; exec_addr_i = 16'h0301; exec_data_i = 16'h3001; commit_v_i = 1'b1;
    tick();
    exec_id_i = 3'd2; exec_addr_i = 16'h0302; exec_data_i = 16'h3002; mem_ready_i = 1'b1;
    total_cnt++; if (mem_v_o !== 1'b1 || mem_addr_o !== 16'h0300)
      $display("FAIL b2b_head0 got v %b addr %h exp v 1 addr 0300", mem_v_o, mem_addr_o); else pass_cnt++;
    tick();
    idle_inputs();
    total_cnt++; if (alloc_id_o !== 3'd4) $display("FAIL b2b_tail got %0d exp 4", alloc_id_o); else pass_cnt++;
    total_cnt++; if (mem_v_o !== 1'b1 || mem_addr_o !== 16'h0301 || mem_data_o !== 16'h3001)
      $display("FAIL b2b_head1 got v %b %h/%h exp v 1 0301/3001", mem_v_o, mem_addr_o, mem_data_o); else pass_cnt++;
    total_cnt++; if (st_clear_vector_o[slot_of(2)] !== 1'b1 || st_clear_vector_o[slot_of(3)] !== 1'b0)
      $display("FAIL b2b_clear got e2 %b e3 %b exp e2 1 e3 0", st_clear_vector_o[slot_of(2)], st_clear_vector_o[slot_of(3)]); else pass_cnt++;
    total_cnt++; if (err_o !== 1'b0) $display("FAIL b2b_err got %b exp 0", err_o); else pass_cnt++;
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 5; i++) do_alloc();
    for (int i = 0; i < 5; i++) do_exec(3'(i), 16'h0200 + 16'(i), 16'h2000 + 16'(i));
    do_commit();
    do_commit();
    flush_i = 1'b1; alloc_v_i = 1'b1; tick(); idle_inputs();
    total_cnt++; if (alloc_id_o !== 3'd2) $display("FAIL flush_tail got %0d exp 2", alloc_id_o); else pass_cnt++;
    total_cnt++; if (mem_v_o !== 1'b1 || mem_addr_o !== 16'h0200)
      $display("FAIL flush_head_kept got v %b addr %h exp v 1 addr 0200", mem_v_o, mem_addr_o); else pass_cnt++;
    total_cnt++; if (st_clear_vector_o[slot_of(2)] !== 1'b1 || st_clear_vector_o[slot_of(4)] !== 1'b1)
      $display("FAIL flush_clear got e2 %b e4 %b exp 1 1", st_clear_vector_o[slot_of(2)], st_clear_vector_o[slot_of(4)]); else pass_cnt++;
    do_alloc();
    total_cnt++; if (st_clear_vector_o[slot_of(2)] !== 1'b0 || st_clear_vector_o[slot_of(3)] !== 1'b1)
      $display("FAIL flush_realloc_clear got e2 %b e3 %b exp e2 0 e3 1", st_clear_vector_o[slot_of(2)], st_clear_vector_o[slot_of(3)]); else pass_cnt++;
    mem_ready_i = 1'b1; tick();
    total_cnt++; if (mem_v_o !== 1'b1 || mem_addr_o !== 16'h0201 || mem_data_o !== 16'h2001)
      $display("FAIL flush_drain1 got v %b %h/%h exp v 1 0201/2001", mem_v_o, mem_addr_o, mem_data_o); else pass_cnt++;
    tick(); mem_ready_i = 1'b0;
    total_cnt++; if (mem_v_o !== 1'b0) $display("FAIL flush_drained got %b exp 0", mem_v_o); else pass_cnt++;
    total_cnt++; if (err_o !== 1'b0) $display("FAIL flush_err_clean got %b exp 0", err_o); else pass_cnt++;
    do_exec(3'd3, 16'h0DEA, 16'hD00D);
    total_cnt++; if (err_o !== 1'b1 || st_clear_vector_o[slot_of(3)] !== 1'b1)
      $display("FAIL flush_entry3_invalid got err %b clr %b exp 1 1", err_o, st_clear_vector_o[slot_of(3)]); else pass_cnt++;
  endtask

  task automatic test_errors();
    apply_reset();
    do_alloc();
    do_commit();
    total_cnt++; if (err_o !== 1'b1) $display("FAIL err_unexec_commit got %b exp 1", err_o); else pass_cnt++;
    total_cnt++; if (mem_v_o !== 1'b0) $display("FAIL err_commit_ignored got %b exp 0", mem_v_o); else pass_cnt++;
    do_exec(3'd5, 16'h1111, 16'h2222);
    total_cnt++; if (err_o !== 1'b1 || st_clear_vector_o[slot_of(5)] !== 1'b1 || st_clear_vector_o[slot_of(0)] !== 1'b0)
      $display("FAIL err_exec_invalid got err %b e5 %b e0 %b exp 1 1 0", err_o,
               st_clear_vector_o[slot_of(5)], st_clear_vector_o[slot_of(0)]); else pass_cnt++;
    exec_v_i = 1'b1; exec_id_i = 3'd0; exec_addr_i = 16'h0444; exec_data_i = 16'h5555; commit_v_i = 1'b1;
    tick(); idle_inputs();
    total_cnt++; if (mem_v_o !== 1'b0 || st_clear_vector_o[slot_of(0)] !== 1'b1)
      $display("FAIL err_same_cycle_commit got v %b clr %b exp v 0 clr 1", mem_v_o, st_clear_vector_o[slot_of(0)]); else pass_cnt++;
    do_commit();
    total_cnt++; if (mem_v_o !== 1'b1 || mem_addr_o !== 16'h0444 || mem_data_o !== 16'h5555)
      $display("FAIL err_recovery got v %b %h/%h exp v 1 0444/5555", mem_v_o, mem_addr_o, mem_data_o); else pass_cnt++;
    total_cnt++; if (err_o !== 1'b1) $display("FAIL err_sticky got %b exp 1", err_o); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_alloc();
    do_alloc();
    do_exec(3'd0, 16'h0777, 16'h7777);
    do_commit();
    total_cnt++; if (mem_v_o !== 1'b1) $display("FAIL areset_pre_mem_v got %b exp 1", mem_v_o); else pass_cnt++;
    #2;
    reset_n_i = 1'b0;
    #1;
    total_cnt++; if (mem_v_o !== 1'b0) $display("FAIL areset_mem_v_drop got %b exp 0", mem_v_o); else pass_cnt++;
    total_cnt++; if (st_clear_vector_o !== 16'hFFFF || alloc_ready_o !== 1'b1 || alloc_id_o !== 3'd0)
      $display("FAIL areset_outputs got clr %h rdy %b id %0d exp FFFF 1 0", st_clear_vector_o, alloc_ready_o, alloc_id_o); else pass_cnt++;
    tick();
    reset_n_i = 1'b1;
    tick();
    total_cnt++; if (alloc_id_o !== 3'd0 || mem_v_o !== 1'b0 || err_o !== 1'b0 || mem_addr_o !== 16'h0000)
      $display("FAIL areset_release got id %0d v %b err %b addr %h exp 0 0 0 0000", alloc_id_o, mem_v_o, err_o, mem_addr_o); else pass_cnt++;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) issue_sb_num_vector_i[k*3 +: 3] = 3'((k + 5) & 7);
    idle_inputs();
    reset_n_i = 1'b0;
    #1;
    test_reset();
    test_single_store();
    test_fill_wrap();
    test_back_to_back();
    test_flush();
    test_errors();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
